// File: rtl/sigbuffer_pkg.sv
// Shared correlator constants: default sizing for the antenna sign-bit
// buffer and the signal-source MUX stage that consumes its replayed beats.
// Also holds the replay FSM state type.
package sigbuffer_pkg;

   localparam int SIG_WIDTH = 12;   // antennas = bits per I or Q word
   localparam int SIG_COUNT = 15;   // samples per frame (bank depth)
   localparam int SIG_TRATE = 6;    // replay passes per frame
   localparam int SIG_CBITS = 4;    // bank index width, COUNT <= 2**CBITS
   localparam int SIG_TBITS = 3;    // pass index width, TRATE <= 2**TBITS

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } play_state_t;

endpackage

// File: rtl/sigbuffer_ram.sv
// Simple dual-port sample store for sigbuffer.
// Address is {bank, index}; with a non-power-of-two bank depth the top
// index slots of each bank are never addressed.
// Ports:
//   clock, reset_n      rising-edge clock, synchronous active-low reset
//                       (clears the read register only, not the array)
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr       read port, data on rd_data one cycle later;
//                       rd_data holds while rd_en is low
module sigbuffer_ram #(
   parameter int DW = 24,
   parameter int AW = 5
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clock) begin
      if (!reset_n)   rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/sigbuffer.sv
// Antenna sign-bit double buffer: captures COUNT raw I/Q samples into one
// bank while the other bank is replayed TRATE times to the signal-source
// MUX stage. A bank that fills while the replay is still busy is dropped
// and overflow_o latches; a replay is never cut short except by reset.
// Ports:
//   clock, reset_n               clock, synchronous active-low reset
//   sig_valid_i, sig_idata_i,
//   sig_qdata_i                  raw sample strobe and I/Q sign bits
//   valid_o, first_o, last_o     replayed beat framing (no backpressure)
//   taddr_o                      replay pass index of the beat
//   idata_o, qdata_o             replayed I/Q word
//   overflow_o                   sticky: a filled capture bank was dropped
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | nothing to replay; a filled bank swaps in immediately
// ST_PLAY | reading replay bank at rptr for pass; TRATE*COUNT reads total
module sigbuffer
   import sigbuffer_pkg::*;
#(
   parameter int WIDTH = SIG_WIDTH,
   parameter int COUNT = SIG_COUNT,
   parameter int TRATE = SIG_TRATE,
   parameter int CBITS = SIG_CBITS,
   parameter int TBITS = SIG_TBITS
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             sig_valid_i,
   input  logic [WIDTH-1:0] sig_idata_i,
   input  logic [WIDTH-1:0] sig_qdata_i,
   output logic             valid_o,
   output logic             first_o,
   output logic             last_o,
   output logic [TBITS-1:0] taddr_o,
   output logic [WIDTH-1:0] idata_o,
   output logic [WIDTH-1:0] qdata_o,
   output logic             overflow_o
);

   localparam logic [CBITS-1:0] IDX_LAST  = CBITS'(COUNT - 1);
   localparam logic [TBITS-1:0] PASS_LAST = TBITS'(TRATE - 1);

   play_state_t      state, state_nxt;
   logic [CBITS-1:0] wptr, wptr_nxt;
   logic [CBITS-1:0] rptr, rptr_nxt;
   logic [TBITS-1:0] pass, pass_nxt;
   logic             bank, bank_nxt;     // capture bank; replay uses ~bank
   logic             fill, final_read, swap, playing;
   logic [2*WIDTH-1:0] rd_data;

   always_comb begin
      state_nxt  = state;
      wptr_nxt   = wptr;
      rptr_nxt   = rptr;
      pass_nxt   = pass;
      bank_nxt   = bank;
      playing    = (state == ST_PLAY);
      fill       = sig_valid_i && (wptr == IDX_LAST);
      final_read = playing && (rptr == IDX_LAST) && (pass == PASS_LAST);
      // A fill coinciding with the last read hands over with no idle gap.
      swap       = fill && (!playing || final_read);

      if (sig_valid_i) wptr_nxt = fill ? '0 : wptr + 1'b1;
      if (swap)        bank_nxt = ~bank;

      case (state)
         ST_IDLE: begin
            if (swap) state_nxt = ST_PLAY;
         end
         ST_PLAY: begin
            if (rptr == IDX_LAST) begin
               rptr_nxt = '0;
               pass_nxt = (pass == PASS_LAST) ? '0 : pass + 1'b1;
            end else begin
               rptr_nxt = rptr + 1'b1;
            end
            if (final_read && !swap) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         wptr  <= '0;
         rptr  <= '0;
         pass  <= '0;
         bank  <= 1'b0;
      end else begin
         state <= state_nxt;
         wptr  <= wptr_nxt;
         rptr  <= rptr_nxt;
         pass  <= pass_nxt;
         bank  <= bank_nxt;
      end
   end

   // Framing registers line up with the RAM read register, so a beat's
   // flags, pass index and data all appear one cycle after its read.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         valid_o    <= 1'b0;
         first_o    <= 1'b0;
         last_o     <= 1'b0;
         taddr_o    <= '0;
         overflow_o <= 1'b0;
      end else begin
         valid_o <= playing;
         first_o <= playing && (rptr == '0) && (pass == '0);
         last_o  <= final_read;
         if (playing) taddr_o <= pass;
         if (fill && !swap) overflow_o <= 1'b1;
      end
   end

   sigbuffer_ram #(
      .DW (2*WIDTH),
      .AW (CBITS+1)
   ) u_ram (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (reset_n && sig_valid_i),
      .wr_addr ({bank, wptr}),
      .wr_data ({sig_idata_i, sig_qdata_i}),
      .rd_en   (playing),
      .rd_addr ({~bank, rptr}),
      .rd_data (rd_data)
   );

   assign idata_o = rd_data[2*WIDTH-1:WIDTH];
   assign qdata_o = rd_data[WIDTH-1:0];

endmodule

// File: tb/tb_sigbuffer.sv
// Self-checking bench for sigbuffer. A behavioural model at each rising edge
// decides from timing alone whether a filled bank is replayed or dropped and
// queues the expected beats (with their output cycle); a monitor pops and
// compares them one time unit after each edge.
module tb_sigbuffer;
   import sigbuffer_pkg::*;

   localparam int W     = SIG_WIDTH;
   localparam int C     = SIG_COUNT;
   localparam int T     = SIG_TRATE;
   localparam int TB    = SIG_TBITS;
   localparam int BEATS = C * T;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          sig_valid_i = 1'b0;
   logic [W-1:0]  sig_idata_i = '0;
   logic [W-1:0]  sig_qdata_i = '0;
   logic          valid_o, first_o, last_o, overflow_o;
   logic [TB-1:0] taddr_o;
   logic [W-1:0]  idata_o, qdata_o;

   sigbuffer dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .sig_valid_i (sig_valid_i),
      .sig_idata_i (sig_idata_i),
      .sig_qdata_i (sig_qdata_i),
      .valid_o     (valid_o),
      .first_o     (first_o),
      .last_o      (last_o),
      .taddr_o     (taddr_o),
      .idata_o     (idata_o),
      .qdata_o     (qdata_o),
      .overflow_o  (overflow_o)
   );

   always #5 clock = ~clock;

   typedef struct {
      int            cyc;
      logic          first;
      logic          last;
      logic [TB-1:0] taddr;
      logic [W-1:0]  i;
      logic [W-1:0]  q;
   } beat_t;

   beat_t        sb[$];
   int           checks = 0;
   int           failures = 0;

   int           cyc = 0;
   int           last_final = 0;
   int           acc_fill_cyc = 0;
   int           m_wptr = 0;
   logic [2*W-1:0] m_mem [C];
   logic         ovf_exp = 1'b0;
   logic         rst_edge = 1'b1;

   int           firsts = 0;
   int           lasts = 0;
   int           last_last_cyc = -1000;
   int           first_gap = 0;
   logic [TB-1:0] prev_taddr = '0;
   logic [W-1:0] prev_i = '0;
   logic [W-1:0] prev_q = '0;

   // Model: a filled bank replays if the previous frame's final read is in
   // this cycle or earlier, otherwise it is dropped.
   always @(posedge clock) begin
      cyc++;
      rst_edge = !reset_n;
      if (!reset_n) begin
         m_wptr     = 0;
         last_final = 0;
         ovf_exp    = 1'b0;
         sb.delete();
      end else if (sig_valid_i) begin
         m_mem[m_wptr] = {sig_idata_i, sig_qdata_i};
         if (m_wptr == C-1) begin
            m_wptr = 0;
            if (cyc >= last_final) begin
               for (int k = 0; k < BEATS; k++) begin
                  beat_t b;
                  b.cyc   = cyc + 1 + k;
                  b.first = (k == 0);
                  b.last  = (k == BEATS-1);
                  b.taddr = TB'(k / C);
                  b.i     = m_mem[k % C][2*W-1:W];
                  b.q     = m_mem[k % C][W-1:0];
                  sb.push_back(b);
               end
               last_final   = cyc + BEATS;
               acc_fill_cyc = cyc;
            end else begin
               ovf_exp = 1'b1;
            end
         end else begin
            m_wptr++;
         end
      end
   end

   // Monitor / scoreboard compare.
   always @(posedge clock) begin
      beat_t e;
      #1;
      checks++;
      if (overflow_o !== ovf_exp) begin
         failures++;
         $display("FAIL overflow cyc=%0d actual=%b required=%b", cyc, overflow_o, ovf_exp);
      end
      if (valid_o === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat cyc=%0d taddr=%0d i=%0h", cyc, taddr_o, idata_o);
         end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || first_o !== e.first || last_o !== e.last ||
                taddr_o !== e.taddr || idata_o !== e.i || qdata_o !== e.q) begin
               failures++;
               $display("FAIL beat actual cyc=%0d f=%b l=%b t=%0d i=%0h q=%0h required cyc=%0d f=%b l=%b t=%0d i=%0h q=%0h",
                        cyc, first_o, last_o, taddr_o, idata_o, qdata_o,
                        e.cyc, e.first, e.last, e.taddr, e.i, e.q);
            end
         end
         if (first_o === 1'b1) begin
            firsts++;
            first_gap = cyc - last_last_cyc;
         end
         if (last_o === 1'b1) begin
            lasts++;
            last_last_cyc = cyc;
         end
      end else begin
         checks++;
         if (first_o !== 1'b0 || last_o !== 1'b0) begin
            failures++;
            $display("FAIL flags_without_valid cyc=%0d actual f=%b l=%b required 0 0", cyc, first_o, last_o);
         end
         checks++;
         if (rst_edge ? (taddr_o !== '0 || idata_o !== '0 || qdata_o !== '0)
                      : (taddr_o !== prev_taddr || idata_o !== prev_i || qdata_o !== prev_q)) begin
            failures++;
            $display("FAIL hold cyc=%0d actual t=%0d i=%0h q=%0h required t=%0d i=%0h q=%0h", cyc,
                     taddr_o, idata_o, qdata_o,
                     rst_edge ? '0 : prev_taddr, rst_edge ? '0 : prev_i, rst_edge ? '0 : prev_q);
         end
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_beat cyc=%0d actual valid=0 required beat taddr=%0d i=%0h", cyc, e.taddr, e.i);
         end
      end
      prev_taddr = taddr_o;
      prev_i     = idata_o;
      prev_q     = qdata_o;
   end

   // Drives one sample for one cycle, then gap-1 idle cycles. Call at a negedge.
   task automatic send(input logic [W-1:0] i, input logic [W-1:0] q, input int gap);
      sig_valid_i = 1'b1;
      sig_idata_i = i;
      sig_qdata_i = q;
      @(negedge clock);
      sig_valid_i = 1'b0;
      repeat (gap - 1) @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (5) begin
         @(negedge clock);
         sig_valid_i = 1'($urandom);
         sig_idata_i = W'($urandom);
         sig_qdata_i = W'($urandom);
      end
      checks++;
      if ({valid_o, first_o, last_o, overflow_o} !== 4'b0 || taddr_o !== '0 ||
          idata_o !== '0 || qdata_o !== '0) begin
         failures++;
         $display("FAIL reset_outputs actual v=%b f=%b l=%b o=%b t=%0d i=%0h q=%0h required all 0",
                  valid_o, first_o, last_o, overflow_o, taddr_o, idata_o, qdata_o);
      end
      sig_valid_i = 1'b0;
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_single_frame();
      int f0, l0;
      logic [W-1:0] kv;
      f0 = firsts;
      l0 = lasts;
      for (int k = 0; k < C-1; k++) begin
         kv = W'(k);
         send(kv, ~kv, T);
      end
      kv = W'(C-1);
      sig_valid_i = 1'b1;
      sig_idata_i = kv;
      sig_qdata_i = ~kv;
      @(negedge clock);
      sig_valid_i = 1'b0;
      checks++;
      if (valid_o !== 1'b0) begin
         failures++;
         $display("FAIL latency_n1 actual valid=%b required 0", valid_o);
      end
      @(negedge clock);
      kv = '0;
      checks++;
      if (valid_o !== 1'b1 || first_o !== 1'b1 || taddr_o !== '0 || idata_o !== kv || qdata_o !== ~kv) begin
         failures++;
         $display("FAIL latency_n2 actual v=%b f=%b t=%0d i=%0h q=%0h required 1 1 0 0 %0h",
                  valid_o, first_o, taddr_o, idata_o, qdata_o, ~kv);
      end
      for (int n = 0; n < 2*BEATS && sb.size() > 0; n++) @(negedge clock);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL single_drain actual pending=%0d required 0", sb.size());
      end
      checks++;
      if (firsts != f0 + 1 || lasts != l0 + 1) begin
         failures++;
         $display("FAIL single_frames actual first=%0d last=%0d required 1 1", firsts - f0, lasts - l0);
      end
   endtask

   task automatic test_back_to_back();
      int f0, l0;
      f0 = firsts;
      l0 = lasts;
      for (int k = 0; k < 3*C; k++) send(W'($urandom), W'($urandom), T);
      for (int n = 0; n < 3*BEATS && sb.size() > 0; n++) @(negedge clock);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL b2b_drain actual pending=%0d required 0", sb.size());
      end
      checks++;
      if (firsts != f0 + 3 || lasts != l0 + 3) begin
         failures++;
         $display("FAIL b2b_frames actual first=%0d last=%0d required 3 3", firsts - f0, lasts - l0);
      end
      checks++;
      if (first_gap != 1) begin
         failures++;
         $display("FAIL b2b_gap actual %0d required 1", first_gap);
      end
      checks++;
      if (overflow_o !== 1'b0) begin
         failures++;
         $display("FAIL b2b_overflow actual %b required 0", overflow_o);
      end
   endtask

   task automatic test_overflow();
      int f0, l0;
      f0 = firsts;
      l0 = lasts;
      for (int k = 0; k < 2*C-1; k++) send(W'($urandom), W'($urandom), 5);
      checks++;
      if (overflow_o !== 1'b0) begin
         failures++;
         $display("FAIL ovf_early actual %b required 0", overflow_o);
      end
      send(W'($urandom), W'($urandom), 5);
      checks++;
      if (overflow_o !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set actual %b required 1", overflow_o);
      end
      for (int k = 0; k < C; k++) send(W'($urandom), W'($urandom), 5);
      for (int n = 0; n < 3*BEATS && sb.size() > 0; n++) @(negedge clock);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL ovf_drain actual pending=%0d required 0", sb.size());
      end
      checks++;
      if (firsts != f0 + 2 || lasts != l0 + 2 || overflow_o !== 1'b1) begin
         failures++;
         $display("FAIL ovf_frames actual first=%0d last=%0d ovf=%b required 2 2 1",
                  firsts - f0, lasts - l0, overflow_o);
      end
   endtask

   task automatic test_mid_reset();
      int f0, l0, target;
      f0 = firsts;
      l0 = lasts;
      for (int k = 0; k < C; k++) send(W'($urandom), W'($urandom), T);
      // partial capture into the other bank, to be discarded by the reset
      for (int k = 0; k < 5; k++) send(W'($urandom), W'($urandom), T);
      target = acc_fill_cyc + 41;
      for (int n = 0; n < 4*BEATS && cyc < target; n++) @(negedge clock);
      checks++;
      if (cyc != target || valid_o !== 1'b1 || taddr_o !== TB'(40 / C)) begin
         failures++;
         $display("FAIL rst_at_beat40 actual cyc=%0d v=%b t=%0d required cyc=%0d v=1 t=%0d",
                  cyc, valid_o, taddr_o, target, 40 / C);
      end
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      checks++;
      if (valid_o !== 1'b0 || last_o !== 1'b0 || overflow_o !== 1'b0) begin
         failures++;
         $display("FAIL rst_abort actual v=%b l=%b o=%b required 0 0 0", valid_o, last_o, overflow_o);
      end
      repeat (BEATS + 10) @(negedge clock);
      checks++;
      if (firsts != f0 + 1 || lasts != l0) begin
         failures++;
         $display("FAIL rst_no_last actual first=%0d last=%0d required 1 0", firsts - f0, lasts - l0);
      end
      for (int k = 0; k < C; k++) send(W'($urandom), W'($urandom), 2);
      for (int n = 0; n < 2*BEATS && sb.size() > 0; n++) @(negedge clock);
      checks++;
      if (sb.size() != 0 || firsts != f0 + 2 || lasts != l0 + 1) begin
         failures++;
         $display("FAIL rst_reload actual pending=%0d first=%0d last=%0d required 0 2 1",
                  sb.size(), firsts - f0, lasts - l0);
      end
   endtask

   task automatic test_aligned_swap();
      int f0, target;
      f0 = firsts;
      for (int k = 0; k < C; k++) send(W'(k + 100), W'(k + 200), 2);
      target = acc_fill_cyc + BEATS - C;
      for (int n = 0; n < 2*BEATS && cyc < target; n++) @(negedge clock);
      checks++;
      if (cyc != target) begin
         failures++;
         $display("FAIL align_wait actual cyc=%0d required %0d", cyc, target);
      end
      for (int k = 0; k < C; k++) send(W'(k + 300), W'(k + 400), 1);
      for (int n = 0; n < 3*BEATS && sb.size() > 0; n++) @(negedge clock);
      checks++;
      if (sb.size() != 0 || firsts != f0 + 2 || first_gap != 1) begin
         failures++;
         $display("FAIL align_swap actual pending=%0d first=%0d gap=%0d required 0 2 1",
                  sb.size(), firsts - f0, first_gap);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overflow();
      test_mid_reset();
      test_aligned_swap();
      repeat (3) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
